// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_issue_ctrl : issue/complete sequencer between decode and FPU datapath  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

package fpu_pkg;
  typedef enum logic [4:0] {
    FPU_NOP     = 5'd0,
    FPU_ADD     = 5'd1,
    FPU_SUB     = 5'd2,
    FPU_MUL     = 5'd3,
    FPU_DIV     = 5'd4,
    FPU_SQRT    = 5'd5,
    FPU_FMADD   = 5'd6,
    FPU_FMSUB   = 5'd7,
    FPU_FNMADD  = 5'd8,
    FPU_FNMSUB  = 5'd9,
    FPU_MIN     = 5'd10,
    FPU_MAX     = 5'd11,
    FPU_SGNJ    = 5'd12,
    FPU_CMP     = 5'd13,
    FPU_CLASS   = 5'd14,
    FPU_MV      = 5'd15,
    FPU_CVT_F2I = 5'd16,
    FPU_CVT_I2F = 5'd17
  } fpu_op_e;
endpackage

module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  fpu_op_e     in_op_i,
  input  logic [2:0]  in_rm_i,
  input  logic [4:0]  in_rd_i,
  input  logic        in_rd_fp_i,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  input  logic [31:0] in_c_i,
  input  logic        flush_i,
  output logic        fpu_start_o,
  output fpu_op_e     fpu_op_o,
  output logic [2:0]  fpu_rm_o,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  output logic [31:0] fpu_c_o,
  input  logic        fpu_done_i,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_status_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic        wb_fp_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic [4:0]  fflags_q, fflags_d;

  fpu_op_e     op_q;
  logic [2:0]  rm_q;
  logic [31:0] a_q, b_q, c_q;
  logic [4:0]  rd_q;
  logic        rd_fp_q;
  logic [31:0] res_q;
  logic [4:0]  status_q;

  logic        accept;
  logic        accept_op;
  logic        capture;
  logic        wb_hs;
  logic        wdog_expired;

  always_comb begin
    accept       = in_valid_i & in_ready_o;
    accept_op    = accept & (in_op_i != FPU_NOP);
    capture      = (state_q == S_WAIT) & fpu_done_i & ~flush_i;
    wb_hs        = (state_q == S_WB) & wb_ready_i & ~flush_i;
    wdog_expired = (wdog_q == WDOG_LAST) & ~fpu_done_i;
  end

  // A done pulse always beats the watchdog; the watchdog beats a flush that
  // would otherwise restart counting in DRAIN.
  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_op) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = flush_i ? S_DRAIN : S_WAIT;
        wdog_d  = 8'd0;
      end
      S_WAIT: begin
        if (fpu_done_i) begin
          state_d = flush_i ? S_IDLE : S_WB;
        end else if (wdog_expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else if (flush_i) begin
          state_d = S_DRAIN;
          wdog_d  = 8'd0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (fpu_done_i) begin
          state_d = S_IDLE;
        end else if (wdog_expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_WB: begin
        if (flush_i || wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fflags_d = (fflags_clr_i ? 5'd0 : fflags_q) | (wb_hs ? status_q : 5'd0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wdog_q    <= 8'd0;
      timeout_q <= 1'b0;
      fflags_q  <= 5'd0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      fflags_q  <= fflags_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= FPU_NOP;
      rm_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c_q     <= 32'd0;
      rd_q    <= 5'd0;
      rd_fp_q <= 1'b0;
    end else if (accept_op) begin
      op_q    <= in_op_i;
      rm_q    <= in_rm_i;
      a_q     <= in_a_i;
      b_q     <= in_b_i;
      c_q     <= in_c_i;
      rd_q    <= in_rd_i;
      rd_fp_q <= in_rd_fp_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q    <= 32'd0;
      status_q <= 5'd0;
    end else if (capture) begin
      res_q    <= fpu_result_i;
      status_q <= fpu_status_i;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE) & ~flush_i;
  assign fpu_start_o = (state_q == S_LAUNCH);
  assign busy_o      = (state_q != S_IDLE);
  assign wb_valid_o  = (state_q == S_WB);
  assign timeout_o   = timeout_q;
  assign fflags_o    = fflags_q;

  assign fpu_op_o  = op_q;
  assign fpu_rm_o  = rm_q;
  assign fpu_a_o   = a_q;
  assign fpu_b_o   = b_q;
  assign fpu_c_o   = c_q;
  assign wb_rd_o   = rd_q;
  assign wb_fp_o   = rd_fp_q;
  assign wb_data_o = res_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpu_issue_ctrl : randomized self-checking bench for fpu_issue_ctrl      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int T = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  fpu_op_e     in_op_i;
  logic [2:0]  in_rm_i;
  logic [4:0]  in_rd_i;
  logic        in_rd_fp_i;
  logic [31:0] in_a_i, in_b_i, in_c_i;
  logic        flush_i;
  logic        fpu_start_o;
  fpu_op_e     fpu_op_o;
  logic [2:0]  fpu_rm_o;
  logic [31:0] fpu_a_o, fpu_b_o, fpu_c_o;
  logic        fpu_done_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic        wb_fp_o;
  logic [31:0] wb_data_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic        busy_o;
  logic        timeout_o;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
    .in_rm_i(in_rm_i), .in_rd_i(in_rd_i), .in_rd_fp_i(in_rd_fp_i),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_c_i(in_c_i), .flush_i(flush_i),
    .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o), .fpu_rm_o(fpu_rm_o),
    .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_c_o(fpu_c_o),
    .fpu_done_i(fpu_done_i), .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_fp_o(wb_fp_o), .wb_data_o(wb_data_o), .fflags_o(fflags_o),
    .fflags_clr_i(fflags_clr_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [4:0] flags_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic junk_inputs();
    in_op_i      = fpu_op_e'(5'($urandom_range(0, 17)));
    in_rm_i      = 3'($urandom);
    in_rd_i      = 5'($urandom);
    in_rd_fp_i   = 1'($urandom);
    in_a_i       = $urandom;
    in_b_i       = $urandom;
    in_c_i       = $urandom;
    fpu_result_i = $urandom;
    fpu_status_i = 5'($urandom);
  endtask

  // Transaction-level model: the scenario fixes when done/ready/flush occur
  // (cycle k relative to the accept cycle k=0), and the expected outcome is
  // derived from those milestones.
  //   sc 0: normal   1: flush in WAIT before done   2: flush with done
  //   sc 3: flush in WB   4: flush in LAUNCH
  task automatic run_op(input int sc, input fpu_op_e op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] res, input logic [4:0] st, input logic [4:0] rd,
                        input logic fp, input logic [2:0] rm,
                        input int done_dly, input int ready_dly, input int fk, input logic clr_hs);
    int k_done, k_wb, k_hs, ks, k_end;
    bit to, has_wb, hs, exp_wbv;
    k_done = 1 + done_dly;
    ks     = (sc == 1) ? fk + 1 : 2;
    to     = (sc != 2) && (sc != 3) && (k_done - ks > T - 1);
    has_wb = !to && (sc == 0 || sc == 3);
    hs     = has_wb && (sc == 0);
    k_wb   = k_done + 1;
    k_hs   = k_wb + ready_dly;
    if (to)           k_end = ks + T - 1;
    else if (sc == 0) k_end = k_hs;
    else if (sc == 3) k_end = fk;
    else              k_end = k_done;

    for (int k = 0; k <= k_end + 1; k++) begin
      @(negedge clk_i);
      junk_inputs();
      in_valid_i = (k == 0);
      if (k == 0) begin
        in_op_i = op; in_rm_i = rm; in_rd_i = rd; in_rd_fp_i = fp;
        in_a_i = a; in_b_i = b; in_c_i = c;
      end
      flush_i = (k == fk);
      fpu_done_i = (!to && k == k_done) ||
                   ((k <= 1 || (has_wb && k >= k_wb)) && ($urandom_range(0, 1) == 1));
      if (k == k_done) begin
        fpu_result_i = res;
        fpu_status_i = st;
      end
      if (has_wb && k >= k_wb) wb_ready_i = (k == k_hs);
      else                     wb_ready_i = 1'($urandom);
      fflags_clr_i = (hs && k == k_hs) ? clr_hs : 1'b0;
      #1;
      exp_wbv = has_wb && k >= k_wb && k <= k_end;
      chk("busy",     32'(busy_o),      32'(k >= 1 && k <= k_end));
      chk("start",    32'(fpu_start_o), 32'(k == 1));
      chk("in_ready", 32'(in_ready_o),  32'(k == 0 || k == k_end + 1));
      chk("wb_valid", 32'(wb_valid_o),  32'(exp_wbv));
      chk("timeout",  32'(timeout_o),   32'(to && k == k_end + 1));
      chk("fflags",   32'(fflags_o),    32'(flags_m));
      if (k == 1 || k == k_end + 1) begin
        chk("fpu_op", 32'(fpu_op_o), 32'(op));
        chk("fpu_rm", 32'(fpu_rm_o), 32'(rm));
        chk("fpu_a",  fpu_a_o, a);
        chk("fpu_b",  fpu_b_o, b);
        chk("fpu_c",  fpu_c_o, c);
      end
      if (exp_wbv) begin
        chk("wb_data", wb_data_o, res);
        chk("wb_rd",   32'(wb_rd_o), 32'(rd));
        chk("wb_fp",   32'(wb_fp_o), 32'(fp));
      end
      if (hs && k == k_hs) flags_m = (clr_hs ? 5'd0 : flags_m) | st;
    end
  endtask

  // Idle cycles: plain, flag clear, NOP accept, or flush blocking a valid op.
  task automatic gap(input int n);
    int kind;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      junk_inputs();
      kind         = $urandom_range(0, 3);
      in_valid_i   = (kind >= 2);
      in_op_i      = (kind == 2) ? FPU_NOP : FPU_ADD;
      flush_i      = (kind == 3);
      fflags_clr_i = (kind == 1);
      fpu_done_i   = 1'($urandom);
      wb_ready_i   = 1'($urandom);
      #1;
      chk("idle_busy",     32'(busy_o),      32'd0);
      chk("idle_start",    32'(fpu_start_o), 32'd0);
      chk("idle_wb_valid", 32'(wb_valid_o),  32'd0);
      chk("idle_timeout",  32'(timeout_o),   32'd0);
      chk("idle_in_ready", 32'(in_ready_o),  32'(kind != 3));
      chk("idle_fflags",   32'(fflags_o),    32'(flags_m));
      if (kind == 1) flags_m = 5'd0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int sc, dd, rdly, fk;
    rst_i = 1'b1;
    in_valid_i = 1'b0; flush_i = 1'b0; fpu_done_i = 1'b0;
    wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
    junk_inputs();
    flags_m = 5'd0;
    @(negedge clk_i); @(negedge clk_i);
    #1;
    chk("rst_in_ready", 32'(in_ready_o),  32'd1);
    chk("rst_fpu_op",   32'(fpu_op_o),    32'(FPU_NOP));
    chk("rst_busy",     32'(busy_o),      32'd0);
    chk("rst_start",    32'(fpu_start_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o),  32'd0);
    chk("rst_wb_data",  wb_data_o,        32'd0);
    chk("rst_fflags",   32'(fflags_o),    32'd0);
    chk("rst_timeout",  32'(timeout_o),   32'd0);
    chk("rst_fpu_a",    fpu_a_o,          32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op(0, FPU_ADD, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 5'b00000,
           5'd7, 1'b1, 3'd0, 2, 2, -1, 1'b0);
    run_op(0, FPU_DIV, 32'h40A00000, 32'h0, 32'h0, 32'h7F800000, 5'b01000,
           5'd3, 1'b1, 3'd1, 3, 3, -1, 1'b0);
    chk("div_fflags", 32'(fflags_o), 32'h08);
    run_op(0, FPU_MUL, 32'h3DCCCCCD, 32'h3DCCCCCD, 32'h0, 32'h3C23D70B, 5'b00001,
           5'd4, 1'b1, 3'd0, 1, 0, -1, 1'b0);
    chk("nx_fflags", 32'(fflags_o), 32'h09);

    @(negedge clk_i);
    junk_inputs(); in_valid_i = 1'b1; in_op_i = FPU_NOP; flush_i = 1'b0;
    fpu_done_i = 1'b0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
    #1;
    chk("nop_in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("nop_busy",     32'(busy_o),      32'd0);
    chk("nop_start",    32'(fpu_start_o), 32'd0);
    chk("nop_in_ready", 32'(in_ready_o),  32'd1);
    chk("nop_wb_valid", 32'(wb_valid_o),  32'd0);

    run_op(1, FPU_MUL, 32'h1, 32'h2, 32'h3, 32'hDEADBEEF, 5'b11111,
           5'd9, 1'b0, 3'd2, 6, 0, 2, 1'b0);
    run_op(0, FPU_SUB, 32'h40400000, 32'h3F800000, 32'h0, 32'h40000000, 5'b00000,
           5'd10, 1'b1, 3'd0, 1, 1, -1, 1'b0);
    run_op(0, FPU_SQRT, 32'h41000000, 32'h0, 32'h0, 32'h0, 5'b00000,
           5'd11, 1'b1, 3'd0, T + 3, 0, -1, 1'b0);
    run_op(0, FPU_CMP, 32'h7FC00001, 32'h0, 32'h0, 32'h0, 5'b10000,
           5'd12, 1'b0, 3'd0, 1, 0, -1, 1'b0);
    chk("cmp_fflags", 32'(fflags_o), 32'h19);
    run_op(0, FPU_ADD, 32'h3F800001, 32'h33800000, 32'h0, 32'h3F800002, 5'b00001,
           5'd13, 1'b1, 3'd0, 2, 1, -1, 1'b1);
    chk("clr_hs_fflags", 32'(fflags_o), 32'h01);

    for (int it = 0; it < 60; it++) begin
      sc   = $urandom_range(0, 4);
      rdly = $urandom_range(0, 3);
      dd   = $urandom_range(1, T + 2);
      fk   = -1;
      case (sc)
        1: begin dd = $urandom_range(2, T + 4); fk = $urandom_range(2, (dd < T) ? dd : T); end
        2: begin dd = $urandom_range(1, T); fk = 1 + dd; end
        3: begin dd = $urandom_range(1, T); fk = 2 + dd + $urandom_range(0, rdly); end
        4: fk = 1;
        default: ;
      endcase
      run_op(sc, fpu_op_e'(5'($urandom_range(1, 17))), $urandom, $urandom, $urandom,
             $urandom, 5'($urandom), 5'($urandom), 1'($urandom), 3'($urandom),
             dd, rdly, fk, 1'($urandom));
      gap($urandom_range(0, 3));
    end

    @(negedge clk_i);
    junk_inputs(); in_valid_i = 1'b1; in_op_i = FPU_ADD; flush_i = 1'b0;
    fpu_done_i = 1'b0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    fpu_done_i = 1'b1; fpu_status_i = 5'b00001;
    @(negedge clk_i);
    fpu_done_i = 1'b0;
    #1;
    chk("pre_rst_wb_valid", 32'(wb_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_wb_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_wb_busy",     32'(busy_o),     32'd0);
    chk("rst_wb_fflags",   32'(fflags_o),   32'd0);
    flags_m = 5'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
    fpu_done_i = 1'b1;
    @(negedge clk_i);
    fpu_done_i = 1'b0;
    #1;
    chk("stray_done_busy", 32'(busy_o),     32'd0);
    chk("stray_done_wbv",  32'(wb_valid_o), 32'd0);
    gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles to wait for fpu_done_i (legal range 2..255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have ports, in this order:
  - clk_i  in  1  clock.
  - rst_i  in  1  asynchronous active-high reset.
  - in_valid_i  in  1  decoded op offered.
  - in_ready_o  out  1  op accepted when high with in_valid_i.
  - in_op_i  in  fpu_op_e  decoded FPU opcode.
  - in_rm_i  in  3  rounding mode.
  - in_rd_i  in  5  destination register index.
  - in_rd_fp_i  in  1  destination is the FP register file.
  - in_a_i, in_b_i, in_c_i  in  32 each  operands.
  - flush_i  in  1  kill the in-flight op.
  - fpu_start_o  out  1  one-cycle launch pulse.
  - fpu_op_o  out  fpu_op_e  registered op.
  - fpu_rm_o  out  3  registered rounding mode.
  - fpu_a_o, fpu_b_o, fpu_c_o  out  32 each  registered operands.
  - fpu_done_i  in  1  datapath result valid, one-cycle pulse.
  - fpu_result_i  in  32  result.
  - fpu_status_i  in  5  NV/DZ/OF/UF/NX flags.
  - wb_valid_o  out  1  writeback offered.
  - wb_ready_i  in  1  writeback accepted.
  - wb_rd_o  out  5  writeback register index.
  - wb_fp_o  out  1  writeback targets the FP register file.
  - wb_data_o  out  32  writeback data.
  - fflags_o  out  5  sticky accrued exception flags.
  - fflags_clr_i  in  1  clear accrued flags.
  - busy_o  out  1  FSM not in IDLE.
  - timeout_o  out  1  one-cycle watchdog pulse.

Function
REQ-004 SHALL implement an FSM with states IDLE, LAUNCH, WAIT, WB and DRAIN.
REQ-005 in_ready_o SHALL be high only in IDLE with flush_i low.
REQ-006 An accept (in_valid_i & in_ready_o) with in_op_i != FPU_NOP SHALL register op, rm, operands, rd and rd_fp, and go to LAUNCH.
REQ-007 An accept with in_op_i == FPU_NOP SHALL be consumed and SHALL stay in IDLE, with no start, no writeback and no flag update.
REQ-008 In LAUNCH, fpu_start_o SHALL be high for exactly that cycle; the next state SHALL be WAIT, or DRAIN if flush_i is high.
REQ-009 fpu_op_o, fpu_rm_o and fpu_a/b/c_o SHALL hold their registered values from LAUNCH until the next accept.
REQ-010 In WAIT, fpu_done_i SHALL capture result and status and go to WB; wb_valid_o SHALL assert the following cycle.
REQ-011 Minimum accept-to-wb_valid_o latency SHALL be 3 cycles, reached when fpu_done_i arrives in the first WAIT cycle.
REQ-012 In WB, wb_valid_o, wb_rd_o, wb_fp_o and wb_data_o SHALL be stable until wb_ready_i; the handshake cycle SHALL return to IDLE.
REQ-013 fpu_done_i SHALL be ignored in IDLE, LAUNCH and WB.
REQ-014 flush_i in WAIT with fpu_done_i low SHALL go to DRAIN.
REQ-015 flush_i in WAIT with fpu_done_i high SHALL discard the result and go to IDLE.
REQ-016 DRAIN SHALL wait for fpu_done_i, discard it, and go to IDLE.
REQ-017 flush_i in WB SHALL drop the writeback (no flag update) and go to IDLE, even if wb_ready_i is high.
REQ-018 flush_i in IDLE SHALL only block acceptance.
REQ-019 An 8-bit watchdog counter SHALL clear on entry to WAIT or DRAIN and increment each cycle there without fpu_done_i.
REQ-020 When the watchdog counter reaches TIMEOUT_CYCLES-1 without fpu_done_i, the FSM SHALL go to IDLE, pulse timeout_o for one cycle, and produce no writeback.
REQ-021 fpu_done_i in the same cycle as the timeout SHALL win: no timeout, normal done handling.
REQ-022 fflags_o SHALL update only on a completed writeback handshake: next = (fflags_clr_i ? 0 : fflags_o) | captured status.
REQ-023 fflags_clr_i without a handshake SHALL zero fflags_o the next cycle.
REQ-024 Comparison, classify and move ops SHALL still OR in the captured status, because the datapath owns flag generation.
REQ-025 busy_o SHALL be high in every state except IDLE.

Reset
REQ-026 On rst_i, state SHALL be IDLE and the watchdog counter 0.
REQ-027 On rst_i, all outputs SHALL be 0, except in_ready_o = 1 and fpu_op_o = FPU_NOP.
REQ-028 rst_i mid-operation SHALL abandon the op with no writeback; a later stray fpu_done_i SHALL be ignored in IDLE.

Verification
REQ-029 FPU_ADD, a=0x3F800000, b=0x40000000, done 2 cycles after start with result 0x40400000, status 0 -> wb_valid_o 4 cycles after accept; wb_data_o=0x40400000, rd held until wb_ready_i.
REQ-030 FPU_DIV, status 5'b01000, wb_ready_i low 3 cycles -> outputs stable; after handshake fflags_o=5'b01000; a further NX op gives 5'b01001.
REQ-031 FPU_NOP accepted -> no fpu_start_o, no wb_valid_o, in_ready_o stays 1.
REQ-032 flush_i in WAIT, done 5 cycles later -> no writeback, fflags_o unchanged, IDLE after the done, next op accepted normally.
REQ-033 TIMEOUT_CYCLES=8, no done -> timeout_o pulses 8 cycles after entering WAIT, busy_o drops, no writeback.
REQ-034 fflags_clr_i coincident with a handshake carrying NX -> fflags_o=5'b00001.
REQ-035 rst_i asserted in WB -> wb_valid_o=0 immediately, in_ready_o=1.
